fetch_queue: RTL and testbench

- Receiving end of the fetch interface: captures the (pc, instruction) pair presented each cycle by the fetch stage into a small FIFO.
- Drives freeze back to fetch as backpressure.
- Discards wrong-path entries on branch_taken.
- Presents the head entry to decode through a valid/ready handshake, decoupling fetch from decode stalls.

---
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: captures (pc, instruction) pairs from fetch into a DEPTH-entry
// circular buffer, drives freeze as backpressure, flushes on branch_taken and
// hands the head entry to decode through a valid/ready handshake.
// Optional: define FETCH_QUEUE_STATS_EN to add the 16-bit discard_count output.
module fetch_queue #(
   parameter int unsigned BIT_NUMBER = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIT_NUMBER-1:0] pc,
   input  logic [BIT_NUMBER-1:0] instruction,
   input  logic                  branch_taken,
   output logic                  freeze,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIT_NUMBER-1:0] out_pc,
   output logic [BIT_NUMBER-1:0] out_instruction
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [15:0]           discard_count
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [BIT_NUMBER-1:0] mem_pc    [DEPTH];
   logic [BIT_NUMBER-1:0] mem_instr [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   // Status and head read derived from registered state only
   always_comb begin
      freeze          = (count == CNT_W'(DEPTH));
      out_valid       = (count != '0);
      push            = !freeze && !branch_taken;
      pop             = out_valid && out_ready && !branch_taken;
      out_pc          = mem_pc[rd_ptr];
      out_instruction = mem_instr[rd_ptr];
   end

   // Storage write; cleared on reset so the head reads 0 out of reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_pc[i]    <= '0;
            mem_instr[i] <= '0;
         end
      end else if (push) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= instruction;
      end
   end

   // Pointer and occupancy update; flush has priority over push and pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (branch_taken) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   logic [16:0] discard_sum;

   // Buffered entries plus the dropped presented pair, saturating
   always_comb begin
      discard_sum = {1'b0, discard_count} + 17'(count) + 17'd1;
   end

   // Discard statistics counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         discard_count <= '0;
      end else if (branch_taken) begin
         discard_count <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

   localparam int unsigned BN    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [BN-1:0] pc;
   logic [BN-1:0] instruction;
   logic          branch_taken;
   logic          freeze;
   logic          out_valid;
   logic          out_ready;
   logic [BN-1:0] out_pc;
   logic [BN-1:0] out_instruction;
`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0]   discard_count;
`endif

   fetch_queue #(.BIT_NUMBER(BN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
      .branch_taken(branch_taken), .freeze(freeze), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instruction(out_instruction)
`ifdef FETCH_QUEUE_STATS_EN
      , .discard_count(discard_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: queue of {pc, instruction}
   logic [2*BN-1:0] mq[$];
   int              disc;
   logic [BN-1:0]   fetch_pc;
   logic [BN-1:0]   target;
   int              tests;
   int              fails;

   // Apply the queue rules to the model, clock the DUT, then let fetch advance
   task automatic cycle();
      bit full = (mq.size() == DEPTH);
      bit adv  = !full && !branch_taken;
      if (branch_taken) begin
         disc = disc + mq.size() + 1;
         if (disc > 65535) disc = 65535;
         mq.delete();
      end else begin
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (adv) mq.push_back({pc, instruction});
      end
      @(posedge clk);
      @(negedge clk);
      if (branch_taken) begin
         fetch_pc    = target;
         instruction = $urandom;
      end else if (adv) begin
         fetch_pc    = fetch_pc + 32'd4;
         instruction = $urandom;
      end
      pc = fetch_pc;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      branch_taken = 1'b0;
      out_ready    = 1'b0;
      fetch_pc     = 32'd4;
      pc           = fetch_pc;
      instruction  = $urandom;
      target       = 32'h100;
      mq.delete();
      disc = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (out_valid !== 1'b0 || freeze !== 1'b0 || out_pc !== '0 || out_instruction !== '0) begin
         fails++;
         $display("FAIL reset: valid=%b freeze=%b pc=%h instr=%h, want 0 0 0 0",
                  out_valid, freeze, out_pc, out_instruction);
      end
`ifdef FETCH_QUEUE_STATS_EN
      tests++;
      if (discard_count !== 16'd0) begin
         fails++;
         $display("FAIL reset_discard: got %0d want 0", discard_count);
      end
`endif
   endtask

   task automatic test_stream();
      logic [BN-1:0] instr_seq[3];
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         instr_seq[k] = instruction;
         cycle();
         tests++;
         if (out_valid !== 1'b1 || freeze !== 1'b0 || out_pc !== BN'(4 * (k + 1))
             || out_instruction !== instr_seq[k]) begin
            fails++;
            $display("FAIL stream[%0d]: valid=%b freeze=%b pc=%0d instr=%h, want 1 0 %0d %h",
                     k, out_valid, freeze, out_pc, out_instruction, 4 * (k + 1), instr_seq[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle();
         tests++;
         if (freeze !== (k >= 3) || out_pc !== 32'd4) begin
            fails++;
            $display("FAIL backpressure[%0d]: freeze=%b head=%0d, want %b 4", k, freeze, out_pc, k >= 3);
         end
      end
      tests++;
      if (pc !== 32'd20) begin
         fails++;
         $display("FAIL backpressure_pc: fetch pc=%0d want 20 (no duplicates)", pc);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         tests++;
         if (out_valid !== (mq.size() != 0) || freeze !== (mq.size() == DEPTH)
             || (out_valid && {out_pc, out_instruction} !== mq[0])) begin
            fails++;
            $display("FAIL drain[%0d]: valid=%b freeze=%b pc=%0d, want %b %b %0d",
                     k, out_valid, freeze, out_pc, mq.size() != 0, mq.size() == DEPTH, mq[0][2*BN-1:BN]);
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) cycle();
      target       = 32'h200;
      branch_taken = 1'b1;
      out_ready    = 1'b1;
      cycle();
      branch_taken = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || freeze !== 1'b0) begin
         fails++;
         $display("FAIL flush: valid=%b freeze=%b want 0 0", out_valid, freeze);
      end
`ifdef FETCH_QUEUE_STATS_EN
      tests++;
      if (discard_count !== 16'd4) begin
         fails++;
         $display("FAIL flush_discard: got %0d want 4", discard_count);
      end
`endif
      cycle();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
         fails++;
         $display("FAIL flush_target: valid=%b pc=%h want 1 200", out_valid, out_pc);
      end
   endtask

   task automatic test_full_flush();
      do_reset();
      for (int k = 0; k < 5; k++) cycle();
      tests++;
      if (freeze !== 1'b1) begin
         fails++;
         $display("FAIL full_flush_pre: freeze=%b want 1", freeze);
      end
      out_ready    = 1'b1;
      branch_taken = 1'b1;
      cycle();
      branch_taken = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || freeze !== 1'b0) begin
         fails++;
         $display("FAIL full_flush: valid=%b freeze=%b want 0 0", out_valid, freeze);
      end
   endtask

   task automatic test_wrap();
      int seen = 0;
      do_reset();
      for (int k = 0; k < 30 && seen < 10; k++) begin
         out_ready = k[0] ? 1'b0 : 1'b1;
         if (out_valid && out_ready) begin
            seen++;
            tests++;
            if (out_pc !== BN'(4 * seen)) begin
               fails++;
               $display("FAIL wrap[%0d]: pc=%0d want %0d", seen, out_pc, 4 * seen);
            end
         end
         cycle();
      end
      tests++;
      if (seen != 10) begin
         fails++;
         $display("FAIL wrap_count: delivered %0d want 10", seen);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         out_ready    = $urandom_range(0, 2) != 0;
         branch_taken = $urandom_range(0, 9) == 0;
         target       = BN'($urandom_range(0, 1023)) << 2;
         tests++;
         if (out_valid !== (mq.size() != 0) || freeze !== (mq.size() == DEPTH)
             || (out_valid && {out_pc, out_instruction} !== mq[0])) begin
            fails++;
            $display("FAIL random[%0d]: valid=%b freeze=%b pc=%h, want %b %b size=%0d",
                     k, out_valid, freeze, out_pc, mq.size() != 0, mq.size() == DEPTH, mq.size());
         end
`ifdef FETCH_QUEUE_STATS_EN
         tests++;
         if (discard_count !== 16'(disc)) begin
            fails++;
            $display("FAIL random_discard[%0d]: got %0d want %0d", k, discard_count, disc);
         end
`endif
         cycle();
      end
      branch_taken = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 5; k++) cycle();
      #2 rst = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || freeze !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: valid=%b freeze=%b want 0 0", out_valid, freeze);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_full_flush();
      test_wrap();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
